// File: rtl/fd_sched_pkg.sv
// fd_sched_pkg: shared types and helpers for the fast_divider scheduler.
//   fd_sched_state_t : scheduler FSM states
//   rr_pick()        : round-robin winner search over a zero-extended valid
//                      vector. It returns the first set bit at or after the
//                      pointer, wrapping at num_req.
package fd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } fd_sched_state_t;

  // The helper works on a fixed maximum width so that one function serves
  // every NUM_REQ. Callers zero-extend their valid vector to this width.
  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] valid,
                                       input int unsigned ptr,
                                       input int unsigned num_req);
    rr_pick_t    res;
    int unsigned j;
    res.found = 1'b0;
    res.idx   = '0;
    j         = 0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req && !res.found) begin
        j = (ptr + k) % num_req;
        if (valid[j[RR_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fast_divider.sv
// fast_divider: single-cycle combinational unsigned divider.
//   dividend_in, divisor_in : WIDTH-bit unsigned operands
//   quotient_out            : dividend / divisor (all ones when divisor is 0)
//   remainder_out           : dividend % divisor (dividend when divisor is 0)
//   dbz_out                 : divisor is zero
// The deep combinational path is meant to be covered by a multicycle
// constraint in the instantiating block.
module fast_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             dbz_out
);

  always_comb begin
    dbz_out = (divisor_in == '0);
    if (dbz_out) begin
      quotient_out  = '1;
      remainder_out = dividend_in;
    end else begin
      quotient_out  = dividend_in / divisor_in;
      remainder_out = dividend_in % divisor_in;
    end
  end

endmodule

// File: rtl/fd_rr_arbiter.sv
// fd_rr_arbiter: combinational round-robin pick.
//   valid_in   : per-requester request valid
//   ptr_in     : highest-priority index (the pointer register lives in the parent)
//   found_out  : at least one request is valid
//   winner_out : index of the winning requester (0 when none is valid)
module fd_rr_arbiter
  import fd_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid_in,
  input  logic [ID_W-1:0]    ptr_in,
  output logic               found_out,
  output logic [ID_W-1:0]    winner_out
);

  logic [RR_MAX_REQ-1:0] valid_ext;
  rr_pick_t              pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid_in;
    pick                     = rr_pick(valid_ext, 32'(ptr_in), NUM_REQ);
    found_out                = pick.found;
    winner_out               = ID_W'(pick.idx);
  end

endmodule

// File: rtl/fd_scheduler.sv
// fd_scheduler: time-shares one fast_divider between NUM_REQ requesters.
//   clk_in, rst_n_in           : clock and async active-low reset
//   req_valid_in/req_ready_out : per-requester request handshake. Ready is
//                                one-hot on the round-robin winner and
//                                only asserted in IDLE.
//   req_dividend_in/divisor_in : packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid_out/rsp_ready_in : one-hot response handshake to the granted requester
//   rsp_quotient/remainder/dbz : registered results, held until the next capture
//   grant_id_out               : current or last granted requester
//   busy_out                   : operation in flight (COMPUTE or RESPOND)
module fd_scheduler
  import fd_sched_pkg::*;
#(
  parameter  int unsigned WIDTH          = 8,
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned COMPUTE_CYCLES = 2,
  localparam int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [NUM_REQ*WIDTH-1:0] req_divisor_in,
  output logic [NUM_REQ-1:0]       rsp_valid_out,
  input  logic [NUM_REQ-1:0]       rsp_ready_in,
  output logic [WIDTH-1:0]         rsp_quotient_out,
  output logic [WIDTH-1:0]         rsp_remainder_out,
  output logic                     rsp_dbz_out,
  output logic [ID_W-1:0]          grant_id_out,
  output logic                     busy_out
);

  // The counter only has to hold COMPUTE_CYCLES-1.
  localparam int unsigned CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  if (COMPUTE_CYCLES < 1) begin : g_bad_compute_cycles
    $error("fd_scheduler: COMPUTE_CYCLES must be >= 1");
  end
  if (NUM_REQ < 2 || NUM_REQ > RR_MAX_REQ) begin : g_bad_num_req
    $error("fd_scheduler: NUM_REQ must be in 2..32");
  end

  fd_sched_state_t   state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  dvd_arr [NUM_REQ];
  logic [WIDTH-1:0]  dvs_arr [NUM_REQ];
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [WIDTH-1:0]  div_quot, div_rem;
  logic              div_dbz;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign dvd_arr[gi] = req_dividend_in[gi*WIDTH +: WIDTH];
    assign dvs_arr[gi] = req_divisor_in[gi*WIDTH +: WIDTH];
  end

  fd_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid_in   (req_valid_in),
    .ptr_in     (ptr_q),
    .found_out  (found),
    .winner_out (winner)
  );

  // Operands come only from registers, so the divider path is stable for
  // the whole COMPUTE window and can be timed as a multicycle path.
  fast_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .dividend_in   (op_a_q),
    .divisor_in    (op_b_q),
    .quotient_out  (div_quot),
    .remainder_out (div_rem),
    .dbz_out       (div_dbz)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    grant_d = grant_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        // Ready is granted to the winner itself, so found implies a handshake.
        if (found) begin
          op_a_d  = dvd_arr[winner];
          op_b_d  = dvs_arr[winner];
          grant_d = winner;
          ptr_d   = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          cnt_d   = CNT_W'(COMPUTE_CYCLES - 1);
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (cnt_q == '0) begin
          quot_d  = div_quot;
          rem_d   = div_rem;
          dbz_d   = div_dbz;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESPOND: begin
        if (rsp_ready_in[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      grant_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      grant_q <= grant_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Ready is gated by reset so that no requester sees an accept while the
  // block is held in reset.
  assign req_ready_out     = (rst_n_in && state_q == IDLE && found)
                             ? (NUM_REQ'(1) << winner) : '0;
  assign rsp_valid_out     = (state_q == RESPOND) ? (NUM_REQ'(1) << grant_q) : '0;
  assign rsp_quotient_out  = quot_q;
  assign rsp_remainder_out = rem_q;
  assign rsp_dbz_out       = dbz_q;
  assign grant_id_out      = grant_q;
  assign busy_out          = (state_q != IDLE);

endmodule

// File: tb/tb_fd_scheduler.sv
// Testbench for fd_scheduler (WIDTH=8, NUM_REQ=4, COMPUTE_CYCLES=2).
module tb_fd_scheduler;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int CC    = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [7:0]  rsp_q;
  logic [7:0]  rsp_r;
  logic        rsp_dbz;
  logic [1:0]  grant_id;
  logic        busy;

  fd_scheduler #(
    .WIDTH          (WIDTH),
    .NUM_REQ        (NREQ),
    .COMPUTE_CYCLES (CC)
  ) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .req_valid_in      (req_valid),
    .req_ready_out     (req_ready),
    .req_dividend_in   (req_dividend),
    .req_divisor_in    (req_divisor),
    .rsp_valid_out     (rsp_valid),
    .rsp_ready_in      (rsp_ready),
    .rsp_quotient_out  (rsp_q),
    .rsp_remainder_out (rsp_r),
    .rsp_dbz_out       (rsp_dbz),
    .grant_id_out      (grant_id),
    .busy_out          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for any response valid; returns edges waited.
  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid == 4'b0 && n < 20) begin
      tick();
      #1;
      n++;
    end
  endtask

  typedef struct {
    logic        do_reset;
    logic [3:0]  valid;
    logic [31:0] dvd;
    logic [31:0] dvs;
    int          exp_id;
    logic [7:0]  exp_q;
    logic [7:0]  exp_r;
    logic        exp_dbz;
    logic        chk_qr;
  } vec_t;

  vec_t tbl [9];

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    if (v.do_reset) apply_reset();
    req_valid    = v.valid;
    req_dividend = v.dvd;
    req_divisor  = v.dvs;
    rsp_ready    = 4'b1111;
    #1;
    chk($sformatf("vec%0d_ready", idx), 32'(req_ready), 32'd1 << v.exp_id);
    tick();
    req_valid = '0;
    #1;
    wait_rsp(n);
    chk($sformatf("vec%0d_latency", idx), n, CC);
    chk($sformatf("vec%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1 << v.exp_id);
    chk($sformatf("vec%0d_grant", idx), 32'(grant_id), v.exp_id);
    if (v.chk_qr) begin
      chk($sformatf("vec%0d_quot", idx), 32'(rsp_q), 32'(v.exp_q));
      chk($sformatf("vec%0d_rem", idx), 32'(rsp_r), 32'(v.exp_r));
    end
    chk($sformatf("vec%0d_dbz", idx), 32'(rsp_dbz), 32'(v.exp_dbz));
    chk($sformatf("vec%0d_busy", idx), 32'(busy), 1);
    $display("VEC %0d id=%0d q=%0d r=%0d dbz=%0d", idx, grant_id, rsp_q, rsp_r, rsp_dbz);
    tick();
    #1;
    chk($sformatf("vec%0d_idle_rsp", idx), 32'(rsp_valid), 0);
    chk($sformatf("vec%0d_idle_busy", idx), 32'(busy), 0);
  endtask

  // Random-phase reference model state.
  logic [3:0] rv;
  logic [7:0] ra [4];
  logic [7:0] rb [4];
  bit         acc_flag [4];
  bit         have_op;
  int         op_id, last_id, ptr_m, acc_cyc, n_txn, w;
  logic [7:0] m_a, m_b;
  logic [3:0] exp_ready, exp_rsp;

  initial begin
    int n;
    // All-four-valid operands: req i has (50+i)/5.
    tbl[0] = '{1'b1, 4'b0001, 32'h0000_0064, 32'h0000_0007, 0, 8'd14, 8'd2, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 4'b1111, 32'h3534_3332, 32'h0505_0505, 0, 8'd10, 8'd0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 4'b1111, 32'h3534_3332, 32'h0505_0505, 1, 8'd10, 8'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 4'b1111, 32'h3534_3332, 32'h0505_0505, 2, 8'd10, 8'd2, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 4'b1111, 32'h3534_3332, 32'h0505_0505, 3, 8'd10, 8'd3, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 4'b0001, 32'h0000_0032, 32'h0000_0005, 0, 8'd10, 8'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 4'b0100, 32'h0009_0000, 32'h0000_0000, 2, 8'd0,  8'd0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 4'b1010, 32'hFF00_4D00, 32'h1000_0700, 3, 8'd15, 8'd15, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 4'b1010, 32'hFF00_4D00, 32'h1000_0700, 1, 8'd11, 8'd0, 1'b0, 1'b1};

    // Reset with every input active.
    rst_n        = 1'b0;
    req_valid    = 4'b1111;
    rsp_ready    = 4'b1111;
    req_dividend = 32'h1234_5678;
    req_divisor  = 32'h0102_0304;
    tick();
    tick();
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_quot", 32'(rsp_q), 0);
    chk("rst_rem", 32'(rsp_r), 0);
    chk("rst_dbz", 32'(rsp_dbz), 0);
    req_valid = '0;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_busy", 32'(busy), 0);
    end

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Result backpressure with a competing request waiting.
    apply_reset();
    req_dividend = 32'h0000_1464;  // req0 100, req1 20
    req_divisor  = 32'h0000_0307;  // req0 7,   req1 3
    req_valid    = 4'b0001;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    #1;
    wait_rsp(n);
    chk("bp_latency", n, CC);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_quot", 32'(rsp_q), 14);
      chk("bp_rem", 32'(rsp_r), 2);
      chk("bp_grant", 32'(grant_id), 0);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      tick();
      #1;
    end
    rsp_ready = 4'b1110;  // other requesters' ready must be ignored
    tick();
    #1;
    chk("bp_ignore_other", 32'(rsp_valid), 32'h1);
    rsp_ready = 4'b0001;
    tick();
    #1;
    chk("bp_done_busy", 32'(busy), 0);
    chk("bp_req1_ready", 32'(req_ready), 32'h2);
    rsp_ready = 4'b1111;
    tick();
    req_valid = '0;
    #1;
    wait_rsp(n);
    chk("bp_req1_latency", n, CC);
    chk("bp_req1_grant", 32'(grant_id), 1);
    chk("bp_req1_quot", 32'(rsp_q), 6);
    chk("bp_req1_rem", 32'(rsp_r), 2);
    $display("SEQ backpressure id=%0d q=%0d r=%0d", grant_id, rsp_q, rsp_r);
    tick();

    // Reset pulsed mid-COMPUTE discards the operation.
    apply_reset();
    req_dividend = 32'h0128_0011;  // req0 17, req2 40, req3 1
    req_divisor  = 32'h0104_0002;
    req_valid    = 4'b0100;
    #1;
    chk("rc_ready2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    chk("rc_in_compute", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rc_busy_clr", 32'(busy), 0);
    chk("rc_grant_clr", 32'(grant_id), 0);
    chk("rc_rsp_clr", 32'(rsp_valid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < CC + 3; k++) begin
      #1;
      chk("rc_no_rsp", 32'(rsp_valid), 0);
      tick();
    end
    req_valid = 4'b1001;
    #1;
    chk("rc_ptr0_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1;
    wait_rsp(n);
    chk("rc_latency", n, CC);
    chk("rc_grant", 32'(grant_id), 0);
    chk("rc_quot", 32'(rsp_q), 8);
    chk("rc_rem", 32'(rsp_r), 1);
    $display("SEQ reset_in_compute id=%0d q=%0d r=%0d", grant_id, rsp_q, rsp_r);
    tick();

    // Randomized traffic against a transaction-level model.
    apply_reset();
    rv      = '0;
    have_op = 0;
    ptr_m   = 0;
    last_id = 0;
    op_id   = 0;
    acc_cyc = 0;
    n_txn   = 0;
    m_a     = '0;
    m_b     = '0;
    for (int i = 0; i < 4; i++) begin
      ra[i] = '0;
      rb[i] = '0;
      acc_flag[i] = 0;
    end
    for (int cyc = 0; cyc < 1200; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_flag[i] || !rv[i]) begin
          acc_flag[i] = 0;
          rv[i] = 1'b0;
          if ($urandom_range(0, 2) == 0) begin
            rv[i] = 1'b1;
            ra[i] = 8'($urandom);
            rb[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          end
        end else if ($urandom_range(0, 15) == 0) begin
          rv[i] = 1'b0;
        end
        req_dividend[i*8 +: 8] = ra[i];
        req_divisor[i*8 +: 8]  = rb[i];
      end
      req_valid = rv;
      rsp_ready = 4'($urandom_range(0, 15));
      #1;
      exp_ready = '0;
      w = -1;
      if (!have_op) begin
        for (int k = 0; k < NREQ; k++) begin
          if (w < 0 && rv[(ptr_m + k) % NREQ]) w = (ptr_m + k) % NREQ;
        end
        if (w >= 0) exp_ready = 4'(1 << w);
      end
      exp_rsp = (have_op && cyc >= acc_cyc + CC + 1) ? 4'(1 << op_id) : 4'b0;
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      chk("rnd_busy", 32'(busy), 32'(have_op));
      chk("rnd_grant", 32'(grant_id), last_id);
      if (exp_rsp != 0) begin
        chk("rnd_dbz", 32'(rsp_dbz), 32'(m_b == 8'd0));
        if (m_b != 8'd0) begin
          chk("rnd_quot", 32'(rsp_q), 32'(m_a / m_b));
          chk("rnd_rem", 32'(rsp_r), 32'(m_a % m_b));
        end
      end
      if (!have_op && w >= 0) begin
        have_op     = 1;
        op_id       = w;
        last_id     = w;
        m_a         = ra[w];
        m_b         = rb[w];
        acc_cyc     = cyc;
        ptr_m       = (w + 1) % NREQ;
        acc_flag[w] = 1;
      end else if (exp_rsp != 0 && rsp_ready[op_id]) begin
        have_op = 0;
        n_txn++;
        $display("TXN %0d id=%0d a=%0d b=%0d q=%0d r=%0d dbz=%0d",
                 n_txn, op_id, m_a, m_b, rsp_q, rsp_r, rsp_dbz);
      end
      tick();
    end
    chk("rnd_progress", 32'(n_txn > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fd_scheduler.md
Name: fd_scheduler

Overview:
Time-shares one fast_divider instance between NUM_REQ independent requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. Requests are arbitrated round-robin. Operands are registered at grant. The divider is given COMPUTE_CYCLES clocks as a multicycle path, and the result is registered and held until the winning requester accepts it. The block sits between client units (ALU sequencers, test drivers) and the shared combinational divider.

Parameters:
WIDTH, 8, operand/result width passed to fast_divider
NUM_REQ, 4, number of requesters; must be >= 2
COMPUTE_CYCLES, 2, clocks allowed for divider settling; must be >= 1 (elaboration $error otherwise)
ID_W, $clog2(NUM_REQ), localparam, requester index width

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_n_in  input  1  reset, asynchronous, active-low
req_valid_in  input  NUM_REQ  per-requester request valid
req_ready_out  output  NUM_REQ  per-requester accept; at most one bit set
req_dividend_in  input  NUM_REQ*WIDTH  packed dividends, requester i at [i*WIDTH +: WIDTH]
req_divisor_in  input  NUM_REQ*WIDTH  packed divisors, same packing
rsp_valid_out  output  NUM_REQ  one-hot response valid to the granted requester
rsp_ready_in  input  NUM_REQ  per-requester response accept
rsp_quotient_out  output  WIDTH  registered quotient
rsp_remainder_out  output  WIDTH  registered remainder
rsp_dbz_out  output  1  registered divide-by-zero flag
grant_id_out  output  ID_W  index of current/last granted requester
busy_out  output  1  high in COMPUTE and RESPOND

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, counter 0. All outputs 0, including result registers and grant_id_out. If reset is asserted mid-operation, the operation is discarded and no response is issued.
- FSM states: IDLE, COMPUTE, RESPOND.
- IDLE:
  - Winner = first set bit of req_valid_in, searching from the rr pointer upward with wrap.
  - req_ready_out is combinational, one-hot on the winner, and 0 when no request is valid.
  - On valid&ready: capture operands and winner id; grant_id_out <= winner; pointer <= (winner+1) mod NUM_REQ; counter <= COMPUTE_CYCLES-1; go to COMPUTE.
  - A requester may drop valid before acceptance; arbitration is recomputed every cycle.
- COMPUTE:
  - req_ready_out = 0.
  - Divider inputs are driven only from the operand registers.
  - Counter decrements each clock.
  - On the edge where counter==0: capture quotient/remainder/dbz into the result registers; go to RESPOND.
- RESPOND:
  - rsp_valid_out[grant_id] = 1; result outputs are stable.
  - On rsp_ready_in[grant_id]=1: go to IDLE.
  - rsp_ready_in bits of other requesters are ignored.
  - No new request is accepted in the same cycle.
- Latency: rsp_valid_out rises COMPUTE_CYCLES clocks after the accepting edge. Minimum occupancy per operation is COMPUTE_CYCLES+2 clocks.
- Result outputs keep their last value outside RESPOND.
- Divisor 0: dbz_out from fast_divider is registered. Quotient/remainder pass through unmodified. The FSM proceeds normally and never stalls.
- Arithmetic: no width change; the divider's result is registered as produced.

Decomposition:
- Package fd_sched_pkg:
  - state enum fd_sched_state_t {IDLE, COMPUTE, RESPOND}
  - helper function rr_pick(valid, ptr) returning the winner index and a found flag
- Sub-modules:
  - fd_rr_arbiter (combinational round-robin pick from valid and pointer; pointer register stays in fd_scheduler)
  - existing fast_divider, instantiated once

Test Plan (WIDTH=8, NUM_REQ=4, COMPUTE_CYCLES=2):
- Reset asserted, all inputs active -> all outputs 0, req_ready_out=4'b0000; deassert with no requests -> busy_out stays 0.
- req0 valid, 100/7, rsp_ready_in=4'b1111 -> req_ready_out=4'b0001 in the accept cycle; rsp_valid_out=4'b0001 2 clocks after accept; quotient 14, remainder 2, dbz 0; back to IDLE next clock.
- All four valid together (operands 50/5, 51/5, 52/5, 53/5) -> grants in order 0,1,2,3 with quotient 10 and remainders 0,1,2,3; req0 re-asserted afterwards -> granted again (pointer wrap).
- Result backpressure: rsp_ready_in=0 for 5 clocks while req1 valid -> rsp_valid_out, result and grant_id_out stable; req_ready_out=0; busy_out=1; req1 granted only after the response handshake.
- Divisor 0 (dividend 9) -> rsp_dbz_out=1, rsp_valid_out asserted on schedule, FSM returns to IDLE.
- Reset pulsed during COMPUTE of req2 -> no rsp_valid_out; after release req3 and req0 both valid -> req0 granted first (pointer 0).
